// File: rtl/dbus_arbiter.sv
// Round-robin arbiter and command multiplexer for the shared 32-bit DBus.
// Grants are registered. Ownership never moves while the slave holds WaitRequest.
module dbus_arbiter #(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned MAX_HOLD    = 16
) (
  input  logic                        i_Clk,
  input  logic                        i_Reset,
  input  logic [NUM_MASTERS-1:0]      i_M_Req,
  output logic [NUM_MASTERS-1:0]      o_M_Gnt,
  input  logic [NUM_MASTERS*30-1:0]   i_M_Address,
  input  logic [NUM_MASTERS*4-1:0]    i_M_ByteEn,
  input  logic [NUM_MASTERS-1:0]      i_M_Read,
  input  logic [NUM_MASTERS-1:0]      i_M_Write,
  input  logic [NUM_MASTERS*32-1:0]   i_M_WriteData,
  output logic [31:0]                 o_M_ReadData,
  output logic [NUM_MASTERS-1:0]      o_M_WaitRequest,
  output logic [29:0]                 o_Bus_Address,
  output logic [3:0]                  o_Bus_ByteEn,
  output logic                        o_Bus_Read,
  output logic                        o_Bus_Write,
  output logic [31:0]                 o_Bus_WriteData,
  input  logic [31:0]                 i_Bus_ReadData,
  input  logic                        i_Bus_WaitRequest,
  output logic [1:0]                  o_Owner,
  output logic                        o_Busy
);

  localparam int unsigned HoldW   = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HoldW-1:0] HoldMax = HoldW'(MAX_HOLD);
  localparam logic [1:0]  LastIdx = 2'(NUM_MASTERS - 1);

  typedef enum logic {StIdle, StOwned} arbState_t;

  arbState_t              stateQ, stateD;
  logic [1:0]             ownerQ, ownerD;
  logic [1:0]             ptrQ, ptrD;
  logic [HoldW-1:0]       holdQ, holdD;
  logic [NUM_MASTERS-1:0] gntQ, gntD;

  logic [3:0] reqPad;
  logic [1:0] winner;
  logic       ownerReq;
  logic       otherReq;
  logic       holdDone;

  // Index + 1, wrapping at the last master.
  function automatic logic [1:0] incIdx(input logic [1:0] idx);
    return (idx == LastIdx) ? 2'd0 : idx + 2'd1;
  endfunction

  // First requester at or after start, wrapping.
  function automatic logic [1:0] pickWinner(input logic [3:0] req, input logic [1:0] start);
    logic [1:0] idx;
    logic [1:0] win;
    logic       found;
    idx   = start;
    win   = start;
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
      idx = incIdx(idx);
    end
    return win;
  endfunction

  function automatic logic [NUM_MASTERS-1:0] oneHot(input logic [1:0] idx);
    logic [NUM_MASTERS-1:0] v;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      v[i] = (idx == 2'(i));
    end
    return v;
  endfunction

  // Zero-padded so a 2-bit index is always in range.
  assign reqPad = 4'(i_M_Req);

  // State, grant, pointer and hold-counter registers.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      stateQ <= StIdle;
      ownerQ <= 2'd0;
      ptrQ   <= 2'd0;
      holdQ  <= '0;
      gntQ   <= '0;
    end else begin
      stateQ <= stateD;
      ownerQ <= ownerD;
      ptrQ   <= ptrD;
      holdQ  <= holdD;
      gntQ   <= gntD;
    end
  end

  // Arbitration: grant, release, hold-limited handover, all frozen during WaitRequest.
  always_comb begin
    stateD   = stateQ;
    ownerD   = ownerQ;
    ptrD     = ptrQ;
    holdD    = holdQ;
    gntD     = gntQ;
    winner   = 2'd0;
    ownerReq = |(i_M_Req & gntQ);
    otherReq = |(i_M_Req & ~gntQ);
    holdDone = (MAX_HOLD != 0) && (holdQ == HoldMax);
    unique case (stateQ)
      StIdle: begin
        if (|i_M_Req && !i_Bus_WaitRequest) begin
          winner = pickWinner(reqPad, ptrQ);
          stateD = StOwned;
          ownerD = winner;
          gntD   = oneHot(winner);
          holdD  = '0;
        end
      end
      StOwned: begin
        if (otherReq && (MAX_HOLD != 0) && !holdDone) begin
          holdD = holdQ + HoldW'(1);
        end
        if (!i_Bus_WaitRequest) begin
          if (!ownerReq) begin
            stateD = StIdle;
            gntD   = '0;
            ptrD   = incIdx(ownerQ);
            holdD  = '0;
          end else if (holdDone && otherReq) begin
            // Zero-gap handover: search starts past the current owner.
            winner = pickWinner(reqPad, incIdx(ownerQ));
            ptrD   = incIdx(ownerQ);
            ownerD = winner;
            gntD   = oneHot(winner);
            holdD  = '0;
          end
        end
      end
      default: stateD = StIdle;
    endcase
  end

  // Owner command mux onto the bus; everything zero while idle.
  always_comb begin
    o_Bus_Address   = '0;
    o_Bus_ByteEn    = '0;
    o_Bus_Read      = 1'b0;
    o_Bus_Write     = 1'b0;
    o_Bus_WriteData = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (stateQ == StOwned && ownerQ == 2'(i)) begin
        o_Bus_Address   = i_M_Address[30*i +: 30];
        o_Bus_ByteEn    = i_M_ByteEn[4*i +: 4];
        o_Bus_Read      = i_M_Read[i];
        o_Bus_Write     = i_M_Write[i];
        o_Bus_WriteData = i_M_WriteData[32*i +: 32];
      end
    end
  end

  // Non-owners are stalled so a premature access cannot complete.
  always_comb begin
    o_M_WaitRequest = '1;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (gntQ[i]) begin
        o_M_WaitRequest[i] = i_Bus_WaitRequest;
      end
    end
  end

  assign o_M_Gnt      = gntQ;
  assign o_M_ReadData = i_Bus_ReadData;
  assign o_Owner      = ownerQ;
  assign o_Busy       = (stateQ == StOwned);

endmodule

// File: tb/tb_dbus_arbiter.sv
// Scoreboard bench for dbus_arbiter (2 masters, hold limit 4).
// Driver pushes expected outputs per cycle; a negedge monitor pops and compares.
module tb_dbus_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  reqS, rdS, wrS;
  logic        bwS;
  logic [31:0] brd;
  logic [1:0]  gnt, mWait;
  logic [31:0] mRdata, busWdata;
  logic [29:0] busAddr;
  logic [3:0]  busBe;
  logic        busRd, busWr, busy;
  logic [1:0]  owner;

  logic [29:0] addrTab [2];
  logic [3:0]  beTab   [2];
  logic [31:0] wdTab   [2];

  typedef struct {
    string       name;
    logic [1:0]  gnt;
    logic        busy;
    logic [1:0]  owner;
    logic        rd;
    logic        wr;
    logic [29:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [1:0]  mwait;
    logic [31:0] rdata;
  } exp_t;

  exp_t sbQ[$];
  exp_t mon;
  int   nPass;
  int   nTotal;
  int   stepNo;

  initial begin
    addrTab[0] = 30'h0000_0100;
    addrTab[1] = 30'h1900_4000;
    beTab[0]   = 4'hF;
    beTab[1]   = 4'h3;
    wdTab[0]   = 32'h1111_2222;
    wdTab[1]   = 32'hDEAD_BEEF;
  end

  dbus_arbiter #(
    .NUM_MASTERS (2),
    .MAX_HOLD    (4)
  ) dut (
    .i_Clk             (clk),
    .i_Reset           (rst),
    .i_M_Req           (reqS),
    .o_M_Gnt           (gnt),
    .i_M_Address       ({addrTab[1], addrTab[0]}),
    .i_M_ByteEn        ({beTab[1], beTab[0]}),
    .i_M_Read          (rdS),
    .i_M_Write         (wrS),
    .i_M_WriteData     ({wdTab[1], wdTab[0]}),
    .o_M_ReadData      (mRdata),
    .o_M_WaitRequest   (mWait),
    .o_Bus_Address     (busAddr),
    .o_Bus_ByteEn      (busBe),
    .o_Bus_Read        (busRd),
    .o_Bus_Write       (busWr),
    .o_Bus_WriteData   (busWdata),
    .i_Bus_ReadData    (brd),
    .i_Bus_WaitRequest (bwS),
    .o_Owner           (owner),
    .o_Busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input string fld, input logic [63:0] act,
                     input logic [63:0] exp);
    nTotal++;
    if (act !== exp) begin
      $display("FAIL %s.%s actual=%0h expected=%0h", nm, fld, act, exp);
    end else begin
      nPass++;
    end
  endtask

  // Monitor: compare DUT outputs mid-cycle against the oldest expectation.
  always @(negedge clk) begin
    if (sbQ.size() > 0) begin
      mon = sbQ.pop_front();
      chk(mon.name, "gnt",   64'(gnt),      64'(mon.gnt));
      chk(mon.name, "busy",  64'(busy),     64'(mon.busy));
      if (mon.busy) chk(mon.name, "owner", 64'(owner), 64'(mon.owner));
      chk(mon.name, "busRd", 64'(busRd),    64'(mon.rd));
      chk(mon.name, "busWr", 64'(busWr),    64'(mon.wr));
      chk(mon.name, "addr",  64'(busAddr),  64'(mon.addr));
      chk(mon.name, "be",    64'(busBe),    64'(mon.be));
      chk(mon.name, "wdata", 64'(busWdata), 64'(mon.wdata));
      chk(mon.name, "mwait", 64'(mWait),    64'(mon.mwait));
      chk(mon.name, "rdata", 64'(mRdata),   64'(mon.rdata));
    end
  end

  // Drive one cycle of stimulus and queue the outputs expected during it.
  task automatic step(input string nm, input logic r, input logic [1:0] req,
                      input logic [1:0] rd, input logic [1:0] wr, input logic bw,
                      input logic [1:0] eg);
    exp_t e;
    logic k;
    rst  = r;
    reqS = req;
    rdS  = rd;
    wrS  = wr;
    bwS  = bw;
    brd  = 32'h5A00_0000 ^ 32'(stepNo);
    stepNo++;
    k       = eg[1];
    e.name  = nm;
    e.gnt   = eg;
    e.busy  = |eg;
    e.owner = {1'b0, k};
    if (|eg) begin
      e.rd    = rd[k];
      e.wr    = wr[k];
      e.addr  = addrTab[k];
      e.be    = beTab[k];
      e.wdata = wdTab[k];
    end else begin
      e.rd    = 1'b0;
      e.wr    = 1'b0;
      e.addr  = '0;
      e.be    = '0;
      e.wdata = '0;
    end
    e.mwait[0] = eg[0] ? bw : 1'b1;
    e.mwait[1] = eg[1] ? bw : 1'b1;
    e.rdata    = brd;
    sbQ.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    nPass  = 0;
    nTotal = 0;
    stepNo = 0;
    rst    = 1'b1;
    reqS   = 2'b11;
    rdS    = 2'b11;
    wrS    = 2'b11;
    bwS    = 1'b0;
    brd    = '0;
    repeat (2) @(posedge clk);
    #1;
    // Reset with all requests high, then first grant one cycle after release.
    step("t1_rst_hold", 1'b1, 2'b11, 2'b11, 2'b11, 1'b0, 2'b00);
    step("t1_rst_rel",  1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 2'b00);
    step("t1_gnt0",     1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 2'b01);
    // M0 releases: one idle cycle, then M1.
    step("t2_drop0",    1'b0, 2'b10, 2'b00, 2'b00, 1'b0, 2'b01);
    step("t2_idle",     1'b0, 2'b10, 2'b00, 2'b00, 1'b0, 2'b00);
    // M1 reads; slave stalls 3 cycles while M1 drops its request.
    step("t3_rd_w1",    1'b0, 2'b10, 2'b10, 2'b00, 1'b1, 2'b10);
    step("t3_rd_w2",    1'b0, 2'b00, 2'b10, 2'b00, 1'b1, 2'b10);
    step("t3_rd_w3",    1'b0, 2'b00, 2'b10, 2'b00, 1'b1, 2'b10);
    step("t3_rd_done",  1'b0, 2'b00, 2'b10, 2'b00, 1'b0, 2'b10);
    step("t3_idle",     1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00);
    step("t4_req0",     1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 2'b00);
    // Non-owner M1 write is stalled and invisible; hold counter runs.
    step("t5_m1_wr",    1'b0, 2'b11, 2'b00, 2'b10, 1'b0, 2'b01);
    step("t5_m0_wr",    1'b0, 2'b11, 2'b00, 2'b11, 1'b0, 2'b01);
    step("t4_hold3",    1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 2'b01);
    step("t4_hold4",    1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 2'b01);
    // Hold limit reached but the slave stalls: handover deferred.
    step("t4_wait_a",   1'b0, 2'b11, 2'b00, 2'b00, 1'b1, 2'b01);
    step("t4_wait_b",   1'b0, 2'b11, 2'b00, 2'b00, 1'b1, 2'b01);
    step("t4_release",  1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 2'b01);
    step("t4_handover", 1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 2'b10);
    // Reset in the middle of an M1 write.
    step("t6_m1_wr",    1'b0, 2'b11, 2'b00, 2'b10, 1'b0, 2'b10);
    step("t6_rst_mid",  1'b1, 2'b11, 2'b00, 2'b10, 1'b0, 2'b00);
    step("t6_rst_rel",  1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 2'b00);
    step("t6_ptr0",     1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 2'b01);
    step("t6_drop",     1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 2'b01);
    step("t6_idle",     1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00);
    for (int i = 0; i < 10 && sbQ.size() > 0; i++) @(negedge clk);
    if (sbQ.size() > 0) begin
      nTotal++;
      $display("FAIL drain pending=%0d required=0", sbQ.size());
    end
    #1;
    $display("%0d/%0d checks passed", nPass, nTotal);
    $finish;
  end

endmodule
